// File: rtl/pwm_duty_selector.sv
// -----------------------------------------------------------------------------
// pwm_duty_selector
//
// Front end for the PWM generator's 2-bit duty select. Two raw pushbuttons are
// synchronised (2-flop chain each), debounced by one small FSM per button, and
// turned into single-cycle step strobes that drive a saturating up/down duty
// register. Optional hold-to-repeat stepping while a button stays pressed.
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a synchronised level must stay stable (>= 1)
//   REPEAT_CYCLES    cycles between auto-repeat steps while held; 0 = off
//   RESET_DUTY       duty value loaded on reset (0..3)
//   CNT_W            width of debounce/repeat counters
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   btn_up        raw pushbutton, asynchronous, active-high
//   btn_down      raw pushbutton, asynchronous, active-high
//   duty_cycle    registered duty select to the PWM generator
//   duty_changed  one-cycle pulse while a newly changed duty_cycle is presented
//   at_max        duty_cycle == 3
//   at_min        duty_cycle == 0
// -----------------------------------------------------------------------------
module pwm_duty_selector #(
    parameter int         DEBOUNCE_CYCLES = 4,
    parameter int         REPEAT_CYCLES   = 0,
    parameter logic [1:0] RESET_DUTY      = 2'd0,
    parameter int         CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [1:0] duty_cycle,
    output logic       duty_changed,
    output logic       at_max,
    output logic       at_min
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK_PRESS,
        PRESSED,
        CHECK_RELEASE
    } btn_state_t;

    // Button index into the per-button arrays below.
    localparam int BTN_UP = 0;
    localparam int BTN_DN = 1;

    localparam bit             REPEAT_EN = (REPEAT_CYCLES > 0);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Clamped so a disabled repeat never produces a negative terminal count.
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_EN ? REPEAT_CYCLES - 1 : 0);

    logic [1:0]       w_raw;
    logic [1:0]       r_meta;
    logic [1:0]       r_sync;
    btn_state_t       r_state [2];
    logic [CNT_W-1:0] r_cnt   [2];
    logic [CNT_W-1:0] r_rcnt  [2];
    logic [1:0]       w_step;
    logic [1:0]       r_duty;
    logic             r_changed;

    assign w_raw = {btn_down, btn_up};

    // -------------------------------------------------------------------------
    // Two-flop synchronisers. r_sync is the only version of the buttons the
    // rest of the design looks at.
    // -------------------------------------------------------------------------
    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge value of its neighbours, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
        end
    end

    // -------------------------------------------------------------------------
    // Step strobes. Decoded from the current FSM state so the duty register
    // updates on the very edge the FSM enters PRESSED (or hits a repeat).
    // -------------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_step = '0;
        for (int b = 0; b < 2; b++) begin
            case (r_state[b])
                CHECK_PRESS: if (r_sync[b] && (r_cnt[b] == DEB_LAST)) w_step[b] = 1'b1;
                PRESSED:     if (REPEAT_EN && r_sync[b] && (r_rcnt[b] == REP_LAST)) w_step[b] = 1'b1;
                default:     ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Debounce FSMs, one per button, identical behaviour.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                r_state[b] <= IDLE;
                r_cnt[b]   <= '0;
                r_rcnt[b]  <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                case (r_state[b])
                    IDLE: begin
                        if (r_sync[b]) begin
                            r_state[b] <= CHECK_PRESS;
                            r_cnt[b]   <= '0;
                        end
                    end
                    CHECK_PRESS: begin
                        if (!r_sync[b]) begin
                            r_state[b] <= IDLE;
                        end else if (r_cnt[b] == DEB_LAST) begin
                            r_state[b] <= PRESSED;
                            r_rcnt[b]  <= '0;
                        end else begin
                            r_cnt[b] <= r_cnt[b] + CNT_W'(1);
                        end
                    end
                    PRESSED: begin
                        if (!r_sync[b]) begin
                            r_state[b] <= CHECK_RELEASE;
                            r_cnt[b]   <= '0;
                        end else if (REPEAT_EN) begin
                            // Repeat period restarts on every issued step.
                            if (r_rcnt[b] == REP_LAST) r_rcnt[b] <= '0;
                            else                       r_rcnt[b] <= r_rcnt[b] + CNT_W'(1);
                        end
                    end
                    CHECK_RELEASE: begin
                        // A bounce back high resumes the hold without stepping;
                        // only a full release debounce re-arms the button.
                        if (r_sync[b]) begin
                            r_state[b] <= PRESSED;
                            r_rcnt[b]  <= '0;
                        end else if (r_cnt[b] == DEB_LAST) begin
                            r_state[b] <= IDLE;
                        end else begin
                            r_cnt[b] <= r_cnt[b] + CNT_W'(1);
                        end
                    end
                    default: r_state[b] <= IDLE;
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Saturating duty register. Simultaneous up and down steps cancel.
    // r_changed is set only when the value really moves.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_duty    <= RESET_DUTY;
            r_changed <= 1'b0;
        end else begin
            r_changed <= 1'b0;
            if (w_step[BTN_UP] && !w_step[BTN_DN] && (r_duty != 2'd3)) begin
                r_duty    <= r_duty + 2'd1;
                r_changed <= 1'b1;
            end else if (w_step[BTN_DN] && !w_step[BTN_UP] && (r_duty != 2'd0)) begin
                r_duty    <= r_duty - 2'd1;
                r_changed <= 1'b1;
            end
        end
    end

    assign duty_cycle   = r_duty;
    assign duty_changed = r_changed;
    assign at_max       = (r_duty == 2'd3);
    assign at_min       = (r_duty == 2'd0);

endmodule

// File: tb/tb_pwm_duty_selector.sv
// -----------------------------------------------------------------------------
// tb_pwm_duty_selector
//
// Directed bench for pwm_duty_selector. Two instances share clk/reset:
//   dut0 : DEBOUNCE=4, no repeat, RESET_DUTY=0
//   dut_r: DEBOUNCE=4, REPEAT=8,  RESET_DUTY=3
// Inputs change and outputs are sampled on the falling edge; after waiting k
// falling edges from an input change, the bench sees the state after rising
// edge k (edge 1 = first edge that samples the new input).
// -----------------------------------------------------------------------------
module tb_pwm_duty_selector;

    logic       clk = 1'b0;
    logic       reset;
    logic       up0, dn0, up_r, dn_r;
    logic [1:0] duty0, duty_r;
    logic       chg0, chg_r, max0, max_r, min0, min_r;

    int n_checks = 0;
    int n_errors = 0;
    int pulses0  = 0;
    int pulses_r = 0;

    always #5 clk = ~clk;

    pwm_duty_selector #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (0),
        .RESET_DUTY      (2'd0),
        .CNT_W           (20)
    ) dut0 (
        .clk          (clk),
        .reset        (reset),
        .btn_up       (up0),
        .btn_down     (dn0),
        .duty_cycle   (duty0),
        .duty_changed (chg0),
        .at_max       (max0),
        .at_min       (min0)
    );

    pwm_duty_selector #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (8),
        .RESET_DUTY      (2'd3),
        .CNT_W           (20)
    ) dut_r (
        .clk          (clk),
        .reset        (reset),
        .btn_up       (up_r),
        .btn_down     (dn_r),
        .duty_cycle   (duty_r),
        .duty_changed (chg_r),
        .at_max       (max_r),
        .at_min       (min_r)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n falling edges, counting duty_changed pulses seen on the way.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (chg0)  pulses0++;
            if (chg_r) pulses_r++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    // Clean press of dut0's up (dir=0) or down (dir=1): 10 cycles held,
    // 10 cycles released, long enough for both debounces.
    task automatic press0(input bit dir);
        if (dir) dn0 = 1'b1; else up0 = 1'b1;
        tick(10);
        up0 = 1'b0;
        dn0 = 1'b0;
        tick(10);
    endtask

    initial begin
        int p;
        reset = 1'b1;
        up0 = 1'b0; dn0 = 1'b0; up_r = 1'b0; dn_r = 1'b0;

        // ---------------- reset state ----------------
        tick(2);
        check("rst_duty0",   duty0, 0);
        check("rst_at_min0", min0,  1);
        check("rst_at_max0", max0,  0);
        check("rst_chg0",    chg0,  0);
        check("rst_duty_r",  duty_r, 3);
        check("rst_at_max_r", max_r, 1);
        reset = 1'b0;
        tick(3);

        // ---------------- single long press: step at edge 7 ----------------
        pulses0 = 0;
        up0 = 1'b1;
        tick(6);
        check("lat_before_e7", duty0, 0);
        tick(1);
        check("lat_at_e7",     duty0, 1);
        check("lat_chg_e7",    chg0,  1);
        tick(13);
        up0 = 1'b0;
        tick(12);
        check("hold_duty",   duty0,   1);
        check("hold_pulses", pulses0, 1);

        // ---------------- short glitches: no step ----------------
        pulses0 = 0;
        for (int i = 0; i < 5; i++) begin
            up0 = 1'b1;
            tick(3);
            up0 = 1'b0;
            tick(3);
        end
        tick(10);
        check("glitch_duty",   duty0,   1);
        check("glitch_pulses", pulses0, 0);

        // ---------------- four clean presses from 0 ----------------
        do_reset();
        tick(2);
        pulses0 = 0;
        press0(1'b0);
        check("p1_duty", duty0, 1);
        check("p1_max",  max0,  0);
        press0(1'b0);
        check("p2_duty", duty0, 2);
        press0(1'b0);
        check("p3_duty", duty0, 3);
        check("p3_max",  max0,  1);
        p = pulses0;
        press0(1'b0);
        check("p4_duty",   duty0,       3);
        check("p4_max",    max0,        1);
        check("p4_nopulse", pulses0 - p, 0);
        check("p1to4_pulses", pulses0, 3);

        // ---------------- both buttons together from 2 ----------------
        do_reset();
        tick(2);
        press0(1'b0);
        press0(1'b0);
        check("both_pre", duty0, 2);
        pulses0 = 0;
        up0 = 1'b1;
        dn0 = 1'b1;
        tick(20);
        up0 = 1'b0;
        dn0 = 1'b0;
        tick(12);
        check("both_duty",   duty0,   2);
        check("both_pulses", pulses0, 0);

        // ---------------- down presses to floor, no wrap ----------------
        press0(1'b1);
        check("dn1_duty", duty0, 1);
        press0(1'b1);
        check("dn2_duty", duty0, 0);
        check("dn2_min",  min0,  1);
        p = pulses0;
        press0(1'b1);
        check("dn3_duty",    duty0,       0);
        check("dn3_nopulse", pulses0 - p, 0);

        // ---------------- auto-repeat down from 3 ----------------
        do_reset();
        tick(2);
        check("rep_start", duty_r, 3);
        pulses_r = 0;
        dn_r = 1'b1;
        tick(6);
        check("rep_e6",  duty_r, 3);
        tick(1);
        check("rep_e7",  duty_r, 2);
        check("rep_chg7", chg_r, 1);
        tick(7);
        check("rep_e14", duty_r, 2);
        tick(1);
        check("rep_e15", duty_r, 1);
        tick(7);
        check("rep_e22", duty_r, 1);
        tick(1);
        check("rep_e23", duty_r, 0);
        tick(17);
        dn_r = 1'b0;
        tick(12);
        check("rep_end_duty",   duty_r,   0);
        check("rep_end_min",    min_r,    1);
        check("rep_end_pulses", pulses_r, 3);

        // ---------------- reset while held mid-debounce ----------------
        do_reset();
        tick(2);
        press0(1'b0);
        check("mid_pre", duty0, 1);
        up0 = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(2);
        check("mid_rst_duty", duty0, 0);
        check("mid_rst_chg",  chg0,  0);
        reset = 1'b0;
        tick(6);
        check("mid_e6", duty0, 0);
        tick(1);
        check("mid_e7", duty0, 1);
        up0 = 1'b0;
        tick(12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
